ambi_zone_averager: RTL and testbench
=====================================

Name: ambi_zone_averager

Overview:
- Sits directly upstream of the soc_system on-chip RAM slave port (ram_mm_*) and drives it.
- Consumes the captured VGA active-pixel stream and divides each frame into a ZONES_X x ZONES_Y grid of power-of-two-sized zones.
- Computes the truncated mean R/G/B per zone and writes one 32-bit word per zone into a double-banked region of that RAM.
- The HPS reads the completed bank to drive the LED strip.

Parameters:
- ZONES_X, 20, zones per row (≥2).
- ZONES_Y, 15, zone rows per frame (≥1).
- ZONE_W_LOG2, 5, log2 of zone width in pixels (20 x 32 = 640).
- ZONE_H_LOG2, 5, log2 of zone height in lines (15 x 32 = 480).
- BANK_STRIDE, 512, word offset of bank 1; must be ≥ ZONES_X*ZONES_Y, and BANK_STRIDE*2 ≤ 8192.

Ports:
- clk  in  1  pixel/RAM clock (same clock as ram_clk_clk)
- reset_n  in  1  synchronous, active-low reset
- pix_valid  in  1  active pixel present this cycle
- pix_sof  in  1  qualifies the first pixel of a frame (valid only with pix_valid)
- pix_eol  in  1  qualifies the last pixel of a line (valid only with pix_valid)
- pix_r, pix_g, pix_b  in  8 each  pixel colour
- ram_address  out  13  word address
- ram_chipselect  out  1  RAM select
- ram_clken  out  1  RAM clock enable
- ram_write  out  1  write strobe
- ram_writedata  out  32  {8'h00, R_avg, G_avg, B_avg}
- ram_byteenable  out  4  byte enables
- frame_done  out  1  one-cycle pulse when a bank is complete
- frame_bank  out  1  bank of the most recently completed frame
- sync_err  out  1  sticky line-length/sync error flag

Behaviour:
- Reset (synchronous, active-low, clk edge with reset_n=0): all RAM outputs 0; ram_clken 1; frame_done 0; frame_bank 0; sync_err 0; state WAIT_SOF; write bank 0; accumulators cleared.
- Counters: x (0..ZONES_X*2^ZONE_W_LOG2-1) and y (0..ZONES_Y*2^ZONE_H_LOG2-1). Zone column = x >> ZONE_W_LOG2.
- WAIT_SOF: pixels are ignored until pix_valid&pix_sof. That pixel is x=0, y=0 and is accumulated; go to RUN.
- RUN: each valid pixel adds R/G/B into its column's accumulators. Width per channel is 8+ZONE_W_LOG2+ZONE_H_LOG2 bits, with no overflow possible.
- Line end: pix_eol must coincide with x = last. On match, x←0 and y++. Otherwise set sync_err, clear accumulators, and go to WAIT_SOF.
- Missing eol: a valid pixel at x = last without pix_eol is also an error, handled the same way.
- Band end: the eol pixel on a line where y[ZONE_H_LOG2-1:0] is all ones. In that same cycle:
  - shadow[i] ← (acc[i] + current pixel where applicable) >> (ZONE_W_LOG2+ZONE_H_LOG2), truncating;
  - accumulators clear;
  - the flush counter starts.
- FLUSH runs concurrently with RUN. Starting the cycle after band end, it issues ZONES_X consecutive writes, one per cycle:
  - ram_chipselect=1, ram_write=1, ram_byteenable=4'hF;
  - ram_address = bank*BANK_STRIDE + band*ZONES_X + i.
- Flush overlap: geometry guarantees no new band end can occur during a flush.
- Outside flush: ram_write=0, ram_chipselect=0, ram_address and ram_writedata hold their last values.
- Last band: after its final write, frame_done pulses the next cycle, frame_bank ← bank, bank toggles, and the state goes to WAIT_SOF.
- pix_sof mid-frame (in RUN, not at x=0,y=0): set sync_err, clear accumulators, and restart at x=0,y=0 with this pixel accumulated.
  - An in-progress flush completes unaffected.
  - frame_done is not pulsed for the aborted frame; bank is not toggled.
- Pixels and pix_sof arriving in WAIT_SOF without sof are dropped with no error.
- Latency: first RAM write is 1 cycle after the band-end pixel; last write is ZONES_X cycles after it.

Decomposition:
- Shared package ambi_pkg holds:
  - RAM_AW=13, RAM_DW=32;
  - the function acc_width(w,h) = 8+w+h;
  - the write-word packing function;
  - the state enum {WAIT_SOF, RUN}.
- One sub-module, ambi_ram_writer: the shadow register file, flush counter and ram_* driver. It is loaded with a band index and bank, and returns done.

Test Plan (override ZONES_X=2, ZONES_Y=2, ZONE_W_LOG2=1, ZONE_H_LOG2=1, BANK_STRIDE=4 → 4x4 frame):
- Uniform frame, all pixels R=10,G=20,B=30 → addresses 0,1 then 2,3 each write 0x000A141E. frame_done pulses once, frame_bank=0.
- Second identical frame → writes to addresses 4..7; frame_done with frame_bank=1. A third frame returns to 0..3.
- Zone 0 of band 0 pixels R = 1,2,3,5 (sum 11) → written R_avg = 2 (truncated). Other zones are 0 → word 0x00000000.
- Band-end timing → writes appear exactly at cycles +1 and +2 after the band-end eol pixel, with no gap, even with no blanking between lines.
- pix_eol asserted at x=2 → sync_err=1 and no further writes until next sof. The next clean frame writes bank 0 correctly; sync_err stays 1.
- pix_sof at y=3, x=1, during no flush → no frame_done. Restarted frame completes with correct averages into the same bank. reset_n low for 1 cycle mid-flush → ram_write=0 next cycle and frame_bank=0.

Source files
------------

// File: rtl/ambi_pkg.sv
// Shared widths, FSM encoding and word packing for the ambient-light zone averager.
package ambi_pkg;
    localparam int RAM_AW = 13;
    localparam int RAM_DW = 32;

    typedef enum logic {WAIT_SOF, RUN} state_t;

    // Channel accumulator width: one 8-bit sample times 2^(w+h) pixels cannot overflow.
    function automatic int acc_width(input int w, input int h);
        return 8 + w + h;
    endfunction

    function automatic logic [RAM_DW-1:0] pack_word(input logic [7:0] r, input logic [7:0] g,
                                                    input logic [7:0] b);
        return {8'h00, r, g, b};
    endfunction
endpackage

// File: rtl/ambi_ram_writer.sv
// Holds one band of zone averages and streams them to the on-chip RAM, one word per cycle.
module ambi_ram_writer import ambi_pkg::*; #(
    parameter int ZONES_X     = 20,
    parameter int BANK_STRIDE = 512,
    parameter int BW          = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      load,
    input  logic [BW-1:0]             band,
    input  logic                      bank,
    input  logic                      last,
    input  logic [ZONES_X-1:0][7:0]   avg_r,
    input  logic [ZONES_X-1:0][7:0]   avg_g,
    input  logic [ZONES_X-1:0][7:0]   avg_b,
    output logic [RAM_AW-1:0]         ram_address,
    output logic                      ram_chipselect,
    output logic                      ram_write,
    output logic [RAM_DW-1:0]         ram_writedata,
    output logic [3:0]                ram_byteenable,
    output logic                      done
);
    localparam int IW = $clog2(ZONES_X);

    logic [ZONES_X-1:0][7:0] sh_r, sh_g, sh_b;
    logic [IW-1:0]           left;
    logic                    last_q;
    logic [RAM_AW-1:0]       load_base;

    assign load_base = RAM_AW'(bank ? BANK_STRIDE : 0) + RAM_AW'(band) * RAM_AW'(ZONES_X);

    // Zone 0 goes out on the load edge itself; the rest shift down through sh_* one per cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sh_r           <= '0;
            sh_g           <= '0;
            sh_b           <= '0;
            left           <= '0;
            last_q         <= 1'b0;
            done           <= 1'b0;
            ram_address    <= '0;
            ram_chipselect <= 1'b0;
            ram_write      <= 1'b0;
            ram_writedata  <= '0;
            ram_byteenable <= '0;
        end else begin
            done <= 1'b0;
            if (load) begin
                sh_r           <= avg_r >> 8;
                sh_g           <= avg_g >> 8;
                sh_b           <= avg_b >> 8;
                left           <= IW'(ZONES_X - 1);
                last_q         <= last;
                ram_address    <= load_base;
                ram_writedata  <= pack_word(avg_r[0], avg_g[0], avg_b[0]);
                ram_chipselect <= 1'b1;
                ram_write      <= 1'b1;
                ram_byteenable <= 4'hF;
            end else if (left != '0) begin
                sh_r           <= sh_r >> 8;
                sh_g           <= sh_g >> 8;
                sh_b           <= sh_b >> 8;
                left           <= left - IW'(1);
                ram_address    <= ram_address + RAM_AW'(1);
                ram_writedata  <= pack_word(sh_r[0], sh_g[0], sh_b[0]);
                ram_chipselect <= 1'b1;
                ram_write      <= 1'b1;
                ram_byteenable <= 4'hF;
                if (left == IW'(1))
                    done <= last_q;
            end else begin
                ram_chipselect <= 1'b0;
                ram_write      <= 1'b0;
                ram_byteenable <= 4'h0;
            end
        end
    end
endmodule

// File: rtl/ambi_zone_averager.sv
// Per-zone RGB mean of the active video stream, written band by band into a double-banked RAM.
module ambi_zone_averager import ambi_pkg::*; #(
    parameter int ZONES_X     = 20,
    parameter int ZONES_Y     = 15,
    parameter int ZONE_W_LOG2 = 5,
    parameter int ZONE_H_LOG2 = 5,
    parameter int BANK_STRIDE = 512
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic              pix_eol,
    input  logic [7:0]        pix_r,
    input  logic [7:0]        pix_g,
    input  logic [7:0]        pix_b,
    output logic [RAM_AW-1:0] ram_address,
    output logic              ram_chipselect,
    output logic              ram_clken,
    output logic              ram_write,
    output logic [RAM_DW-1:0] ram_writedata,
    output logic [3:0]        ram_byteenable,
    output logic              frame_done,
    output logic              frame_bank,
    output logic              sync_err
);
    localparam int ZW = ZONE_W_LOG2 + ZONE_H_LOG2;
    localparam int AW = acc_width(ZONE_W_LOG2, ZONE_H_LOG2);
    localparam int XN = ZONES_X << ZONE_W_LOG2;
    localparam int YN = ZONES_Y << ZONE_H_LOG2;
    localparam int XW = $clog2(XN);
    localparam int YW = (YN > 1) ? $clog2(YN) : 1;
    localparam int BW = (ZONES_Y > 1) ? $clog2(ZONES_Y) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(XN - 1);
    localparam logic [YW-1:0] Y_MASK = YW'((1 << ZONE_H_LOG2) - 1);
    localparam logic [BW-1:0] B_LAST = BW'(ZONES_Y - 1);

    state_t state, state_nx;
    logic [XW-1:0] x, col;
    logic [YW-1:0] y;
    logic [BW-1:0] band;
    logic          bank, wr_done;
    logic [AW-1:0] acc_r [ZONES_X];
    logic [AW-1:0] acc_g [ZONES_X];
    logic [AW-1:0] acc_b [ZONES_X];
    logic [ZONES_X-1:0]      hit;
    logic [ZONES_X-1:0][7:0] avg_r, avg_g, avg_b;
    logic take_sof, run_pix, at_last, line_err, line_end, band_end, last_band;

    assign ram_clken = 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= WAIT_SOF;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (take_sof)                    state_nx = RUN;
        else if (line_err || last_band)  state_nx = WAIT_SOF;
    end

    always_comb begin
        col       = x >> ZONE_W_LOG2;
        band      = BW'(y >> ZONE_H_LOG2);
        take_sof  = pix_valid & pix_sof;
        run_pix   = (state == RUN) & pix_valid & ~pix_sof;
        at_last   = (x == X_LAST);
        line_err  = run_pix & (pix_eol != at_last);
        line_end  = run_pix & pix_eol & at_last;
        band_end  = line_end & ((y & Y_MASK) == Y_MASK);
        last_band = band_end & (band == B_LAST);
    end

    // Band-end averages include the eol pixel, which has not reached the accumulators yet.
    for (genvar i = 0; i < ZONES_X; i++) begin : g_zone
        logic [AW-1:0] sr, sg, sb;
        assign hit[i]   = (col == XW'(i));
        assign sr       = acc_r[i] + (hit[i] ? AW'(pix_r) : AW'(0));
        assign sg       = acc_g[i] + (hit[i] ? AW'(pix_g) : AW'(0));
        assign sb       = acc_b[i] + (hit[i] ? AW'(pix_b) : AW'(0));
        assign avg_r[i] = sr[ZW +: 8];
        assign avg_g[i] = sg[ZW +: 8];
        assign avg_b[i] = sb[ZW +: 8];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x          <= '0;
            y          <= '0;
            bank       <= 1'b0;
            frame_bank <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            for (int i = 0; i < ZONES_X; i++) begin
                acc_r[i] <= '0;
                acc_g[i] <= '0;
                acc_b[i] <= '0;
            end
        end else begin
            frame_done <= wr_done;
            if (wr_done) begin
                frame_bank <= bank;
                bank       <= ~bank;
            end
            if (take_sof) begin
                if (state == RUN) sync_err <= 1'b1;
                x <= XW'(1);
                y <= '0;
                for (int i = 0; i < ZONES_X; i++) begin
                    acc_r[i] <= (i == 0) ? AW'(pix_r) : '0;
                    acc_g[i] <= (i == 0) ? AW'(pix_g) : '0;
                    acc_b[i] <= (i == 0) ? AW'(pix_b) : '0;
                end
            end else if (line_err) begin
                sync_err <= 1'b1;
                for (int i = 0; i < ZONES_X; i++) begin
                    acc_r[i] <= '0;
                    acc_g[i] <= '0;
                    acc_b[i] <= '0;
                end
            end else if (run_pix) begin
                if (line_end) begin
                    x <= '0;
                    y <= last_band ? '0 : y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
                for (int i = 0; i < ZONES_X; i++) begin
                    if (band_end) begin
                        acc_r[i] <= '0;
                        acc_g[i] <= '0;
                        acc_b[i] <= '0;
                    end else if (hit[i]) begin
                        acc_r[i] <= acc_r[i] + AW'(pix_r);
                        acc_g[i] <= acc_g[i] + AW'(pix_g);
                        acc_b[i] <= acc_b[i] + AW'(pix_b);
                    end
                end
            end
        end
    end

    ambi_ram_writer #(
        .ZONES_X     (ZONES_X),
        .BANK_STRIDE (BANK_STRIDE),
        .BW          (BW)
    ) u_writer (
        .clk            (clk),
        .reset_n        (reset_n),
        .load           (band_end),
        .band           (band),
        .bank           (bank),
        .last           (last_band),
        .avg_r          (avg_r),
        .avg_g          (avg_g),
        .avg_b          (avg_b),
        .ram_address    (ram_address),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_writedata  (ram_writedata),
        .ram_byteenable (ram_byteenable),
        .done           (wr_done)
    );
endmodule

// File: tb/tb_ambi_zone_averager.sv
// Scoreboard bench: frame-level reference model predicts every RAM write and frame_done pulse.
module tb_ambi_zone_averager;
    localparam int ZX = 2, ZY = 2, WL = 1, HL = 1, BS = 4;
    localparam int ZWP = 1 << WL, ZHP = 1 << HL;
    localparam int FW = ZX * ZWP, FH = ZY * ZHP;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        pix_valid = 1'b0, pix_sof = 1'b0, pix_eol = 1'b0;
    logic [7:0]  pix_r = '0, pix_g = '0, pix_b = '0;
    logic [12:0] ram_address;
    logic        ram_chipselect, ram_clken, ram_write;
    logic [31:0] ram_writedata;
    logic [3:0]  ram_byteenable;
    logic        frame_done, frame_bank, sync_err;

    ambi_zone_averager #(
        .ZONES_X(ZX), .ZONES_Y(ZY), .ZONE_W_LOG2(WL), .ZONE_H_LOG2(HL), .BANK_STRIDE(BS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid), .pix_sof(pix_sof),
        .pix_eol(pix_eol), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_clken(ram_clken),
        .ram_write(ram_write), .ram_writedata(ram_writedata), .ram_byteenable(ram_byteenable),
        .frame_done(frame_done), .frame_bank(frame_bank), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [12:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t  wq[$];
    int   dq_cyc[$];
    logic dq_bank[$];
    int   errors = 0, checks = 0;
    int   fr[FH][FW], fg[FH][FW], fb[FH][FW];
    logic mbank = 1'b0, exp_fbank = 1'b0;
    bit   gaps = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write / frame_done the DUT shows must match the head of its queue.
    always @(negedge clk) begin
        wr_t e;
        if (ram_write === 1'b1) begin
            if (wq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write: addr %0h data %0h at cycle %0d", ram_address, ram_writedata, cyc);
            end else begin
                e = wq.pop_front();
                chk("wr_addr", ram_address, e.addr);
                chk("wr_data", ram_writedata, e.data);
                chk("wr_cycle", cyc, e.cyc);
                chk("wr_cs_be", {ram_chipselect, ram_byteenable}, 5'h1F);
            end
        end
        if (frame_done === 1'b1) begin
            if (dq_cyc.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_frame_done at cycle %0d", cyc);
            end else begin
                chk("done_cycle", cyc, dq_cyc.pop_front());
                chk("done_bank", frame_bank, dq_bank.pop_front());
            end
        end
    end

    function automatic logic [31:0] zone_word(input int b, input int z);
        int sr = 0, sg = 0, sb = 0;
        logic [7:0] ar, ag, ab;
        for (int y = b * ZHP; y < (b + 1) * ZHP; y++)
            for (int x = z * ZWP; x < (z + 1) * ZWP; x++) begin
                sr += fr[y][x]; sg += fg[y][x]; sb += fb[y][x];
            end
        ar = 8'(sr / (ZWP * ZHP));
        ag = 8'(sg / (ZWP * ZHP));
        ab = 8'(sb / (ZWP * ZHP));
        return {8'h00, ar, ag, ab};
    endfunction

    task automatic expect_band(input int b, input int k);
        wr_t e;
        for (int z = 0; z < ZX; z++) begin
            e.cyc  = k + 1 + z;
            e.addr = 13'(int'(mbank) * BS + b * ZX + z);
            e.data = zone_word(b, z);
            wq.push_back(e);
        end
        if (b == ZY - 1) begin
            dq_cyc.push_back(k + 1 + ZX);
            dq_bank.push_back(mbank);
            exp_fbank = mbank;
            mbank     = ~mbank;
        end
    endtask

    // Called at posedge+1; the pixel is sampled on the next posedge.
    task automatic put(input int r, input int g, input int b, input logic sof, input logic eol,
                       output int k);
        int n = gaps ? int'($urandom_range(0, 2)) : 0;
        repeat (n) begin @(posedge clk); #1; end
        pix_valid = 1'b1; pix_sof = sof; pix_eol = eol;
        pix_r = 8'(r); pix_g = 8'(g); pix_b = 8'(b);
        k = cyc;
        @(posedge clk); #1;
        pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0;
    endtask

    task automatic send_lines(input int y0, input int y1);
        int k;
        for (int y = y0; y <= y1; y++)
            for (int x = 0; x < FW; x++) begin
                put(fr[y][x], fg[y][x], fb[y][x], (x == 0 && y == 0), (x == FW - 1), k);
                if (x == FW - 1 && (y % ZHP) == ZHP - 1) expect_band(y / ZHP, k);
            end
    endtask

    task automatic fill(input int kind);
        for (int y = 0; y < FH; y++)
            for (int x = 0; x < FW; x++) begin
                case (kind)
                    1:       begin fr[y][x] = 10; fg[y][x] = 20; fb[y][x] = 30; end
                    2:       begin fr[y][x] = 0;  fg[y][x] = 0;  fb[y][x] = 0;  end
                    default: begin
                        fr[y][x] = int'($urandom_range(0, 255));
                        fg[y][x] = int'($urandom_range(0, 255));
                        fb[y][x] = int'($urandom_range(0, 255));
                    end
                endcase
            end
        if (kind == 2) begin
            fr[0][0] = 1; fr[0][1] = 2; fr[1][0] = 3; fr[1][1] = 5;
        end
    endtask

    task automatic junk(input int n);
        int k;
        for (int i = 0; i < n; i++)
            put(int'($urandom_range(0, 255)), 7, 9, 1'b0, (i % FW) == FW - 1, k);
    endtask

    task automatic drain();
        int n = 0;
        while ((wq.size() != 0 || dq_cyc.size() != 0) && n < 100) begin
            @(posedge clk); n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d writes, %0d dones outstanding", wq.size(), dq_cyc.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_write", ram_write, 0);
        chk("rst_cs", ram_chipselect, 0);
        chk("rst_addr", ram_address, 0);
        chk("rst_data", ram_writedata, 0);
        chk("rst_be", ram_byteenable, 0);
        chk("rst_clken", ram_clken, 1);
        chk("rst_done", frame_done, 0);
        chk("rst_bank", frame_bank, 0);
        chk("rst_sync_err", sync_err, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Uniform frames back to back with no blanking: banks 0, 1, 0.
        fill(1);
        for (int f = 0; f < 3; f++) begin
            send_lines(0, FH - 1);
            drain();
            chk("uniform_frame_bank", frame_bank, exp_fbank);
        end

        // Truncated mean: zone 0 of band 0 sums to 11 over 4 pixels.
        fill(2);
        send_lines(0, FH - 1);
        drain();

        // Random content with random inter-pixel gaps.
        gaps = 1'b1;
        for (int f = 0; f < 6; f++) begin
            fill(0);
            send_lines(0, FH - 1);
        end
        drain();
        chk("random_frame_bank", frame_bank, exp_fbank);
        chk("sync_err_clean", sync_err, 0);

        // Early eol on line 0: frame abandoned, nothing written until the next sof.
        fill(0);
        put(fr[0][0], fg[0][0], fb[0][0], 1'b1, 1'b0, k);
        put(fr[0][1], fg[0][1], fb[0][1], 1'b0, 1'b0, k);
        put(fr[0][2], fg[0][2], fb[0][2], 1'b0, 1'b1, k);
        junk(13);
        drain();
        chk("early_eol_sync_err", sync_err, 1);
        fill(0);
        send_lines(0, FH - 1);
        drain();
        chk("sync_err_sticky", sync_err, 1);

        // Missing eol on line 2: band 0 is still written, band 1 never is.
        fill(0);
        send_lines(0, 1);
        for (int x = 0; x < FW; x++) put(fr[2][x], fg[2][x], fb[2][x], 1'b0, 1'b0, k);
        junk(6);
        drain();
        fill(0);
        send_lines(0, FH - 1);
        drain();
        chk("missing_eol_bank", frame_bank, exp_fbank);

        // sof at x=1,y=3: restarted frame lands in the same bank.
        fill(0);
        send_lines(0, 2);
        put(fr[3][0], fg[3][0], fb[3][0], 1'b0, 1'b0, k);
        fill(0);
        send_lines(0, FH - 1);
        drain();
        chk("mid_sof_bank", frame_bank, exp_fbank);

        // One-cycle reset in the middle of a flush.
        gaps = 1'b0;
        fill(0);
        send_lines(0, 1);
        void'(wq.pop_back());
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        mbank = 1'b0;
        @(negedge clk);
        chk("rst_flush_write", ram_write, 0);
        chk("rst_flush_bank", frame_bank, 0);
        chk("rst_flush_sync_err", sync_err, 0);
        @(posedge clk); #1;
        fill(0);
        send_lines(0, FH - 1);
        drain();
        chk("post_reset_bank", frame_bank, exp_fbank);

        chk("writes_outstanding", wq.size(), 0);
        chk("dones_outstanding", dq_cyc.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
